// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads 64-bit instruction words from a fixed-latency RAM.
// After each delivered instruction it prefetches pc + 1 into a one-entry buffer,
// so that a sequential request can be answered at its accept edge.
module instruction_fetch_unit #(
   parameter int unsigned RAM_LATENCY = 1,
   parameter int unsigned MAX_OPCODE  = 17
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] pc,
   output logic [15:0] ram_address,
   input  logic [63:0] ram_q,
   output logic [63:0] instruction,
   output logic [15:0] opcode,
   output logic [15:0] instr_a,
   output logic [15:0] instr_b,
   output logic [15:0] instr_c,
   output logic        done,
   output logic        illegal,
   output logic        hit
);

   typedef enum logic [1:0] {StIdle, StFetch, StDone, StPrefetch} state_t;

   localparam logic [1:0]  LatLast = 2'(RAM_LATENCY);
   localparam logic [15:0] MaxOp   = 16'(MAX_OPCODE);

   state_t      state;
   logic [1:0]  cnt;      // edges elapsed since ram_address was updated
   logic [15:0] last_pc;  // address of the most recently requested instruction
   logic        pf_valid;
   logic [15:0] pf_tag;
   logic [63:0] pf_data;
   logic        pf_pend;  // a request for the in-flight prefetch address is waiting

   // Field views of the captured instruction word.
   assign opcode  = instruction[63:48];
   assign instr_a = instruction[47:32];
   assign instr_b = instruction[31:16];
   assign instr_c = instruction[15:0];
   assign illegal = (instruction[63:48] > MaxOp);

   // Fetch/prefetch control FSM with registered outputs and prefetch buffer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= StIdle;
         cnt         <= '0;
         last_pc     <= '0;
         pf_valid    <= 1'b0;
         pf_tag      <= '0;
         pf_data     <= '0;
         pf_pend     <= 1'b0;
         ram_address <= '0;
         instruction <= '0;
         done        <= 1'b0;
         hit         <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  last_pc <= pc;
                  if (pf_valid && pf_tag == pc) begin
                     instruction <= pf_data;
                     done        <= 1'b1;
                     hit         <= 1'b1;
                     state       <= StDone;
                  end else begin
                     ram_address <= pc;
                     cnt         <= '0;
                     state       <= StFetch;
                  end
               end
            end
            StFetch: begin
               if (cnt == LatLast) begin
                  instruction <= ram_q;
                  if (start) begin
                     done  <= 1'b1;
                     hit   <= 1'b0;
                     state <= StDone;
                  end else begin
                     // Requester gave up: skip DONE and prefetch the successor.
                     ram_address <= last_pc + 16'd1;
                     cnt         <= '0;
                     pf_valid    <= 1'b0;
                     pf_pend     <= 1'b0;
                     state       <= StPrefetch;
                  end
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            StDone: begin
               if (!start) begin
                  done        <= 1'b0;
                  hit         <= 1'b0;
                  ram_address <= last_pc + 16'd1;
                  cnt         <= '0;
                  pf_valid    <= 1'b0;
                  pf_pend     <= 1'b0;
                  state       <= StPrefetch;
               end
            end
            StPrefetch: begin
               if (start && !pf_pend && pc != ram_address) begin
                  // Jump away from the prefetched address: abort and miss.
                  pf_valid    <= 1'b0;
                  ram_address <= pc;
                  last_pc     <= pc;
                  cnt         <= '0;
                  state       <= StFetch;
               end else if (cnt == LatLast) begin
                  pf_data  <= ram_q;
                  pf_tag   <= ram_address;
                  pf_valid <= 1'b1;
                  pf_pend  <= 1'b0;
                  if (start) begin
                     instruction <= ram_q;
                     last_pc     <= ram_address;
                     done        <= 1'b1;
                     hit         <= 1'b1;
                     state       <= StDone;
                  end else begin
                     state <= StIdle;
                  end
               end else begin
                  cnt <= cnt + 2'd1;
                  if (start) pf_pend <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
